// File: rtl/vrf_op_sequencer.sv
// Lane-wise vector op sequencer for the 4-entry vector register file.
// Each accepted command reads two source registers, computes a per-lane
// result (add/sub with optional unsigned saturation, move, splat) and
// issues exactly one VRF write, with a fixed four-cycle op time.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// READ  | source addresses on vreg1/vreg2, operands captured at edge
// EXEC  | per-lane result computed into vdataw at edge
// WRITE | VRFWrite/done asserted for one cycle, op retired
module vrf_op_sequencer #(
  parameter int LANE_W = 8,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic                      cmd_sat,
  input  logic [1:0]                cmd_vd,
  input  logic [1:0]                cmd_vs1,
  input  logic [1:0]                cmd_vs2,
  input  logic [LANE_W-1:0]         cmd_imm,
  output logic [1:0]                vreg1,
  output logic [1:0]                vreg2,
  input  logic [LANE_W*LANES-1:0]   vdata1,
  input  logic [LANE_W*LANES-1:0]   vdata2,
  output logic [1:0]                vregw,
  output logic [LANE_W*LANES-1:0]   vdataw,
  output logic                      VRFWrite,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          op_count
);

  localparam int VW = LANE_W * LANES;

  localparam logic [1:0] OP_VADD   = 2'd0;
  localparam logic [1:0] OP_VSUB   = 2'd1;
  localparam logic [1:0] OP_VMOV   = 2'd2;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t state, next_state;

  logic [1:0]        op_q;
  logic              sat_q;
  logic [1:0]        vd_q;
  logic [LANE_W-1:0] imm_q;
  logic [VW-1:0]     op_a, op_b;
  logic [VW-1:0]     result;

  // State register; reset aborts any op in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and handshake decode.
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = ~reset;
        if (cmd_valid) next_state = READ;
      end
      READ:    next_state = EXEC;
      EXEC:    next_state = WRITE;
      WRITE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Each lane has its own adder with one extra bit for carry/borrow,
  // so nothing propagates across lane boundaries.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W-1:0] a, b;
    logic [LANE_W:0]   sum, diff;
    logic [LANE_W-1:0] lane_res;
    assign a    = op_a[i*LANE_W +: LANE_W];
    assign b    = op_b[i*LANE_W +: LANE_W];
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign lane_res = (op_q == OP_VADD) ? ((sat_q && sum[LANE_W])  ? {LANE_W{1'b1}} : sum[LANE_W-1:0]) :
                      (op_q == OP_VSUB) ? ((sat_q && diff[LANE_W]) ? {LANE_W{1'b0}} : diff[LANE_W-1:0]) :
                      (op_q == OP_VMOV) ? a : imm_q;
    assign result[i*LANE_W +: LANE_W] = lane_res;
  end

  // Command latch, operand capture, result/write-port registers and counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      sat_q    <= 1'b0;
      vd_q     <= '0;
      imm_q    <= '0;
      vreg1    <= '0;
      vreg2    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      vregw    <= '0;
      vdataw   <= '0;
      op_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            sat_q <= cmd_sat;
            vd_q  <= cmd_vd;
            imm_q <= cmd_imm;
            vreg1 <= cmd_vs1;
            vreg2 <= cmd_vs2;
          end
        end
        READ: begin
          op_a <= vdata1;
          op_b <= vdata2;
        end
        EXEC: begin
          vregw  <= vd_q;
          vdataw <= result;
        end
        WRITE:   op_count <= op_count + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign VRFWrite = (state == WRITE);
  assign done     = (state == WRITE);
  assign busy     = (state != IDLE);

endmodule
